// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard controller: mux3 select codes,
// the per-stage pipeline record and the effective-write helper.
package fwd_pkg;

   localparam int FWD_REG_W = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic                 valid;
      logic [FWD_REG_W-1:0] dest;
      logic                 regwrite;
      logic                 memtoreg;
   } stage_rec_t;

   // $0 is hard-wired to zero, so writes to it are never visible to consumers.
   function automatic logic eff_write(input stage_rec_t rec);
      return rec.valid & rec.regwrite & (rec.dest != '0);
   endfunction

endpackage

// File: rtl/fwd_cmp.sv
// Priority compare of one source register against the EX and MEM records;
// the newest producer (EX) wins over MEM, otherwise the register file is used.
module fwd_cmp
   import fwd_pkg::*;
#(
   parameter int REG_W = FWD_REG_W
) (
   input  logic [REG_W-1:0] src,
   input  stage_rec_t       ex,
   input  stage_rec_t       mem,
   output logic [1:0]       sel
);

   always_comb begin
      // NOTE: default assignment first so every path drives sel and no latch is inferred.
      sel = FWD_RF;
      if (eff_write(ex) && (ex.dest == src)) begin
         sel = FWD_MEM;
      end else if (eff_write(mem) && (mem.dest == src)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/fwd_ctrl.sv
// Hazard and forwarding controller: tracks EX/MEM/WB destination records,
// registers the mux3 selects for EX operands and raises the load-use stall.
// Optional perf counters are built when FWD_PERF_EN is defined.
module fwd_ctrl
   import fwd_pkg::*;
#(
   parameter int REG_W = FWD_REG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hold,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_regwrite,
   input  logic             id_memtoreg,
   output logic             stall,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             wb_regwrite,
   output logic [REG_W-1:0] wb_dest
`ifdef FWD_PERF_EN
   ,
   output logic [15:0]      perf_stall_cnt,
   output logic [15:0]      perf_fwd_cnt
`endif
);

   stage_rec_t ex_q, mem_q, wb_q;
   stage_rec_t ex_d;
   logic       issue;
   logic [1:0] sel_a, sel_b;
   logic [1:0] fwd_a_d, fwd_b_d;

   // A load still in EX cannot supply its data yet; flush and hold both override.
   assign stall = id_valid & ex_q.valid & ex_q.memtoreg & (ex_q.dest != '0) &
                  ((ex_q.dest == id_rs) | (ex_q.dest == id_rt)) & ~flush & ~hold;

   assign issue = id_valid & ~stall & ~flush;

   always_comb begin
      ex_d = '0;
      if (issue) begin
         ex_d.valid    = 1'b1;
         ex_d.dest     = id_dest;
         ex_d.regwrite = id_regwrite;
         ex_d.memtoreg = id_memtoreg;
      end
   end

   fwd_cmp #(.REG_W(REG_W)) u_cmp_a (
      .src (id_rs),
      .ex  (ex_q),
      .mem (mem_q),
      .sel (sel_a)
   );

   fwd_cmp #(.REG_W(REG_W)) u_cmp_b (
      .src (id_rt),
      .ex  (ex_q),
      .mem (mem_q),
      .sel (sel_b)
   );

   // A bubble entering EX must not steer the operand muxes.
   assign fwd_a_d = issue ? sel_a : FWD_RF;
   assign fwd_b_d = issue ? sel_b : FWD_RF;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         fwd_a <= FWD_RF;
         fwd_b <= FWD_RF;
      end else if (!hold) begin
         // NOTE: non-blocking assignments so every stage shifts from the pre-edge values.
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= ex_d;
         fwd_a <= fwd_a_d;
         fwd_b <= fwd_b_d;
      end
   end

   assign wb_regwrite = eff_write(wb_q);
   assign wb_dest     = wb_q.dest;

`ifdef FWD_PERF_EN
   logic fwd_hit;

   assign fwd_hit = (fwd_a_d != FWD_RF) || (fwd_b_d != FWD_RF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_fwd_cnt   <= '0;
      end else if (!hold) begin
         if (stall && (perf_stall_cnt != 16'hFFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
         end
         if (fwd_hit && (perf_fwd_cnt != 16'hFFFF)) begin
            perf_fwd_cnt <= perf_fwd_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: directed hazard sequences plus randomized
// traffic, checked against an instruction-history reference model.
module tb_fwd_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       hold = 1'b0;
   logic       flush = 1'b0;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs = '0;
   logic [4:0] id_rt = '0;
   logic [4:0] id_dest = '0;
   logic       id_regwrite = 1'b0;
   logic       id_memtoreg = 1'b0;
   logic       stall;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;
   logic       wb_regwrite;
   logic [4:0] wb_dest;
`ifdef FWD_PERF_EN
   logic [15:0] perf_stall_cnt;
   logic [15:0] perf_fwd_cnt;
`endif

   always #5 clk = ~clk;

   fwd_ctrl #(.REG_W(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .hold        (hold),
      .flush       (flush),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_dest     (id_dest),
      .id_regwrite (id_regwrite),
      .id_memtoreg (id_memtoreg),
      .stall       (stall),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b),
      .wb_regwrite (wb_regwrite),
      .wb_dest     (wb_dest)
`ifdef FWD_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_fwd_cnt   (perf_fwd_cnt)
`endif
   );

   // Reference model: the last three instructions (or bubbles) that entered EX,
   // oldest first; the newest is in EX, the one before in MEM, then WB.
   typedef struct {
      bit v;
      int dest;
      bit rw;
      bit ld;
   } ins_t;

   typedef struct {
      bit       stall;
      bit [1:0] fa;
      bit [1:0] fb;
      bit       wbr;
      int       wbd;
      int       psc;
      int       pfc;
   } exp_t;

   ins_t     hist[$];
   exp_t     sb[$];
   bit [1:0] m_fa;
   bit [1:0] m_fb;
   int       m_psc;
   int       m_pfc;
   bit       last_stall;
   int       n_chk;
   int       n_pass;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ins_t stage_at(int k);
      ins_t e = '{default: 0};
      if (hist.size() > k) e = hist[hist.size() - 1 - k];
      return e;
   endfunction

   function automatic bit writes(ins_t i);
      return i.v && i.rw && (i.dest != 0);
   endfunction

   // Newest producer wins: one instruction ahead -> MEM ALU result, two ahead -> WB result.
   function automatic bit [1:0] sel_for(int r);
      if (writes(stage_at(0)) && stage_at(0).dest == r) return 2'b10;
      if (writes(stage_at(1)) && stage_at(1).dest == r) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_clear();
      hist.delete();
      m_fa = 2'b00;
      m_fb = 2'b00;
      m_psc = 0;
      m_pfc = 0;
      last_stall = 1'b0;
   endtask

   task automatic drive(input bit v, input int rs, input int rt, input int dest,
                        input bit rw, input bit ld, input bit fl, input bit hd);
      exp_t e;
      ins_t ex;
      ins_t wb;
      ins_t ni;
      bit   st;
      bit   iss;
      @(posedge clk);
      #1;
      id_valid    = v;
      id_rs       = rs[4:0];
      id_rt       = rt[4:0];
      id_dest     = dest[4:0];
      id_regwrite = rw;
      id_memtoreg = ld;
      flush       = fl;
      hold        = hd;
      ex = stage_at(0);
      wb = stage_at(2);
      st = v && ex.v && ex.ld && (ex.dest != 0) && (ex.dest == rs || ex.dest == rt) && !fl && !hd;
      e.stall = st;
      e.fa    = m_fa;
      e.fb    = m_fb;
      e.wbr   = writes(wb);
      e.wbd   = wb.dest;
      e.psc   = m_psc;
      e.pfc   = m_pfc;
      sb.push_back(e);
      last_stall = st;
      if (!hd) begin
         iss  = v && !st && !fl;
         m_fa = iss ? sel_for(rs) : 2'b00;
         m_fb = iss ? sel_for(rt) : 2'b00;
         if (st && m_psc < 65535) m_psc++;
         if ((m_fa != 2'b00 || m_fb != 2'b00) && m_pfc < 65535) m_pfc++;
         ni.v    = iss;
         ni.dest = iss ? dest : 0;
         ni.rw   = iss && rw;
         ni.ld   = iss && ld;
         hist.push_back(ni);
         if (hist.size() > 3) void'(hist.pop_front());
      end
   endtask

   task automatic nop();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n       = 1'b0;
      id_valid    = 1'b0;
      flush       = 1'b0;
      hold        = 1'b0;
      id_regwrite = 1'b0;
      id_memtoreg = 1'b0;
      #1;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
      check("rst_fwd_b", {30'd0, fwd_b}, 32'd0);
      check("rst_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
      check("rst_wb_dest", {27'd0, wb_dest}, 32'd0);
`ifdef FWD_PERF_EN
      check("rst_perf_stall", {16'd0, perf_stall_cnt}, 32'd0);
      check("rst_perf_fwd", {16'd0, perf_fwd_cnt}, 32'd0);
`endif
      model_clear();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: every sampled cycle is compared against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("stall", {31'd0, stall}, {31'd0, e.stall});
            check("fwd_a", {30'd0, fwd_a}, {30'd0, e.fa});
            check("fwd_b", {30'd0, fwd_b}, {30'd0, e.fb});
            check("wb_regwrite", {31'd0, wb_regwrite}, {31'd0, e.wbr});
            if (e.wbr) check("wb_dest", {27'd0, wb_dest}, e.wbd);
`ifdef FWD_PERF_EN
            check("perf_stall_cnt", {16'd0, perf_stall_cnt}, e.psc);
            check("perf_fwd_cnt", {16'd0, perf_fwd_cnt}, e.pfc);
`endif
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int r_rs, r_rt, r_dest;
      bit r_v, r_rw, r_ld;
      model_clear();
      n_chk  = 0;
      n_pass = 0;
      do_reset();

      // add $3,$1,$2 ; sub $4,$3,$5
      drive(1, 1, 2, 3, 1, 0, 0, 0);
      drive(1, 3, 5, 4, 1, 0, 0, 0);
      nop(); nop(); nop();
      // add $3,$1,$2 ; nop ; or $6,$7,$3  then the same with two nops
      drive(1, 1, 2, 3, 1, 0, 0, 0);
      nop();
      drive(1, 7, 3, 6, 1, 0, 0, 0);
      drive(1, 1, 2, 3, 1, 0, 0, 0);
      nop(); nop();
      drive(1, 7, 3, 6, 1, 0, 0, 0);
      nop(); nop(); nop();
      // two producers of $3, consumer with rs == rt
      drive(1, 1, 2, 3, 1, 0, 0, 0);
      drive(1, 4, 5, 3, 1, 0, 0, 0);
      drive(1, 3, 3, 8, 1, 0, 0, 0);
      nop(); nop(); nop();
      // lw $4,0($1) ; add $5,$4,$2 (consumer held in ID across the stall)
      drive(1, 1, 0, 4, 1, 1, 0, 0);
      drive(1, 4, 2, 5, 1, 0, 0, 0);
      drive(1, 4, 2, 5, 1, 0, 0, 0);
      nop(); nop(); nop();
      // writes to $0 never forward and loads to $0 never stall
      drive(1, 1, 2, 0, 1, 1, 0, 0);
      drive(1, 0, 0, 9, 1, 0, 0, 0);
      drive(1, 0, 0, 9, 1, 0, 0, 0);
      nop(); nop(); nop();
      // load-use collides with a flush; then a 3-cycle hold with forwarding live
      drive(1, 1, 0, 4, 1, 1, 0, 0);
      drive(1, 4, 2, 5, 1, 0, 1, 0);
      drive(1, 5, 6, 7, 1, 0, 0, 0);
      drive(1, 7, 5, 8, 1, 0, 0, 1);
      drive(1, 7, 5, 8, 1, 0, 0, 1);
      drive(1, 7, 5, 8, 1, 0, 0, 1);
      drive(1, 7, 5, 8, 1, 0, 0, 0);
      nop(); nop();
      // reset while a forward is active
      drive(1, 1, 2, 3, 1, 0, 0, 0);
      drive(1, 3, 5, 4, 1, 0, 0, 0);
      do_reset();

      r_v = 0; r_rs = 0; r_rt = 0; r_dest = 0; r_rw = 0; r_ld = 0;
      for (int i = 0; i < 1500; i++) begin
         if (!last_stall) begin
            r_v    = ($urandom_range(0, 9) < 8);
            r_rs   = $urandom_range(0, 4);
            r_rt   = $urandom_range(0, 4);
            r_dest = $urandom_range(0, 4);
            r_ld   = ($urandom_range(0, 3) == 0);
            r_rw   = r_ld || ($urandom_range(0, 4) != 0);
         end
         if (i == 700) do_reset();
         drive(r_v, r_rs, r_rt, r_dest, r_rw, r_ld,
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      end

      @(negedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Hazard and forwarding controller for the pipelined MIPS core: the producer side of the 3:1 operand-forwarding muxes. Tracks destination registers of in-flight instructions through EX, MEM and WB; generates the registered 2-bit select pair for the two EX-stage `mux3` instances (operand A, operand B); raises a load-use stall. Sits beside the ID/EX pipeline register, fed by decode.

## Interface
Parameters:
- `REG_W`, 5, register-address width

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `hold`  in  1  global freeze (memory wait); no internal state changes
- `flush`  in  1  squash the ID instruction (taken branch/jump)
- `id_valid`  in  1  ID holds a real instruction
- `id_rs`, `id_rt`  in  REG_W  source registers of ID instruction
- `id_dest`  in  REG_W  destination register of ID instruction
- `id_regwrite`  in  1  ID instruction writes `id_dest`
- `id_memtoreg`  in  1  ID instruction is a load
- `stall`  out  1  combinational; hold PC and IF/ID, bubble into EX
- `fwd_a`, `fwd_b`  out  2  registered mux3 selects for EX operands A/B
- `wb_regwrite`  out  1  WB-stage write enable to register file
- `wb_dest`  out  REG_W  WB-stage write address

## Operation
- Select encoding: 00 = register file (mux input a), 01 = WB result (input b), 10 = MEM ALU result (input c). 11 never driven.
- Internal stage records EX, MEM, WB: {valid, dest, regwrite, memtoreg}. Effective write = valid & regwrite & dest != 0.
- `stall` = id_valid & EX.valid & EX.memtoreg & EX.dest != 0 & (EX.dest == id_rs | EX.dest == id_rt) & ~flush & ~hold.
- Advance (each edge with hold = 0): WB <= MEM, MEM <= EX; EX <= ID record if id_valid & ~stall & ~flush, else bubble (valid 0).
- Select for source s entering EX: 10 if current EX effective-writes s; else 01 if current MEM effective-writes s; else 00. Newest producer wins. Bubble entering EX gives fwd_a = fwd_b = 00.
- Sources matching only the current WB entry get 00: register file writes in the first half-cycle and reads in the second.
- `wb_regwrite` = WB effective write; `wb_dest` = WB.dest.

## Timing
- Reset (async assert, sync release): all stage valids 0, fwd_a = fwd_b = 00, wb_regwrite = 0, wb_dest = 0, stall = 0. Reset mid-operation discards all in-flight records.
- Select latency: fwd_a/fwd_b valid for exactly the cycles the instruction occupies EX; they update on the same edge as the ID/EX register.
- Load-use: stall high 1 cycle; next edge the load moves to MEM, a bubble enters EX; following cycle stall low and the consumer enters EX with select 01.
- flush and stall same cycle: flush wins, stall = 0, bubble enters EX.
- hold = 1: all records, selects and counters keep their value; stall forced 0.
- rs == rt: fwd_a and fwd_b identical.

## Configuration
- `FWD_PERF_EN` defined: adds outputs `perf_stall_cnt` (16 bits, increments each cycle stall = 1) and `perf_fwd_cnt` (16 bits, increments on each advance where fwd_a or fwd_b next value != 00). Both saturate at 16'hFFFF, reset to 0, frozen by hold.
- Not defined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package `fwd_pkg`: select constants FWD_RF (00), FWD_WB (01), FWD_MEM (10); stage-record typedef; REG_W default.
- One sub-module `fwd_cmp`: combinational priority compare of one source against EX and MEM records, returning the 2-bit select; instantiated twice (A, B).

## Test plan
- Assert rst_n = 0 mid-sequence -> fwd_a = fwd_b = 00, wb_regwrite = 0, stall = 0 immediately, no clock needed.
- add $3,$1,$2 then sub $4,$3,$5 -> fwd_a = 10, fwd_b = 00 while sub in EX.
- add $3,$1,$2; nop; or $6,$7,$3 -> fwd_b = 01 while or in EX; with two nops -> 00.
- add $3; add $3; add $8,$3,$3 -> fwd_a = fwd_b = 10 (newest producer wins).
- lw $4,0($1) then add $5,$4,$2 -> stall = 1 one cycle, EX bubble with selects 00, then fwd_a = 01; writes to $0 never forward or stall.
- Load-use with flush = 1 same cycle -> stall = 0, bubble enters EX; hold = 1 for 3 cycles -> outputs and (with FWD_PERF_EN) counters unchanged.
